// File: rtl/fifo_pb_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_pb_ctrl
// Push-button driven FIFO. It takes the debounced write, read and clear levels
// as commands and uses the switch value as the write payload. Each command is
// edge-qualified, so a button that is held down is accepted only once.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   wr_btn     write command (level), din is pushed on its rising edge
//   rd_btn     read command (level), head word is popped into dout
//   clr_btn    clear command (level), empties the FIFO and clears the flags
//   din        write payload (switches)
//   dout       last popped word, registered and held between reads
//   dout_valid one-cycle pulse in the cycle after an accepted read
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   overflow   sticky, set when a write is attempted while full
//   underflow  sticky, set when a read is attempted while empty
// -----------------------------------------------------------------------------
module fifo_pb_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_btn,
    input  logic             rd_btn,
    input  logic             clr_btn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // Display-tracking FSM. It records the most recent accepted operation.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WROTE = 2'd1,
        READ  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Command bit order: 0 = write, 1 = read, 2 = clear.
    logic [2:0] btn_in;
    logic [2:0] btn_q_reg;
    logic [2:0] btn_ev;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg,  count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             dout_valid_reg;
    logic             overflow_reg, underflow_reg;

    logic wr_ev, rd_ev, clr_ev;
    logic wr_acc, rd_acc, ovf_set, udf_set;

    assign btn_in = {clr_btn, rd_btn, wr_btn};

    // An event fires in the first cycle that a level is high.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            assign btn_ev[gi] = btn_in[gi] & ~btn_q_reg[gi];
        end
    endgenerate

    assign wr_ev  = btn_ev[0];
    assign rd_ev  = btn_ev[1];
    assign clr_ev = btn_ev[2];

    always_ff @(posedge clk) begin
        if (!rst_n) btn_q_reg <= '0;
        else        btn_q_reg <= btn_in;
    end

    // A clear discards any write or read that arrives in the same cycle.
    // A write into a full FIFO is allowed when a read in the same cycle
    // frees a slot.
    always_comb begin
        wr_acc  = rst_n & ~clr_ev & wr_ev & (~full | rd_ev);
        rd_acc  = rst_n & ~clr_ev & rd_ev & ~empty;
        ovf_set = ~clr_ev & wr_ev & full & ~rd_ev;
        udf_set = ~clr_ev & rd_ev & empty;
    end

    always_comb begin
        count_next = count_reg;
        if (clr_ev)
            count_next = '0;
        else if (wr_acc && !rd_acc)
            count_next = count_reg + 1'b1;
        else if (rd_acc && !wr_acc)
            count_next = count_reg - 1'b1;
    end

    // The storage array is not reset. When the FIFO is full with a write
    // and a read in the same cycle, both pointers address the same slot.
    // The read sees the old word, which is the correct head.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            dout_valid_reg <= rd_acc;
            if (clr_ev) begin
                wr_ptr_reg    <= '0;
                rd_ptr_reg    <= '0;
                overflow_reg  <= 1'b0;
                underflow_reg <= 1'b0;
            end else begin
                if (wr_acc)  wr_ptr_reg    <= wr_ptr_reg + 1'b1;
                if (rd_acc) begin
                    rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    dout_reg   <= mem[rd_ptr_reg];
                end
                if (ovf_set) overflow_reg  <= 1'b1;
                if (udf_set) underflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (clr_ev)
            state_next = IDLE;
        else if (state_reg == ERR)
            state_next = ERR;
        else if (ovf_set || udf_set)
            state_next = ERR;
        else if (rd_acc)
            state_next = READ;
        else if (wr_acc)
            state_next = WROTE;
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign count      = count_reg;
    assign full       = (count_reg == FULL_COUNT);
    assign empty      = (count_reg == '0);
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_pb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_pb_ctrl
// Testbench for fifo_pb_ctrl. It runs directed scenarios and then randomized
// button traffic. Every cycle is compared against a queue-based model of the
// FIFO rules.
// -----------------------------------------------------------------------------
module tb_fifo_pb_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_btn, rd_btn, clr_btn;
    logic [3:0] din;
    logic [3:0] dout;
    logic       dout_valid;
    logic [3:0] count;
    logic       full, empty, overflow, underflow;

    always #5 clk = ~clk;

    fifo_pb_ctrl #(.WIDTH(4), .DEPTH(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_btn     (wr_btn),
        .rd_btn     (rd_btn),
        .clr_btn    (clr_btn),
        .din        (din),
        .dout       (dout),
        .dout_valid (dout_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;

    // Reference model state.
    int         m_q[$];
    logic [3:0] m_dout;
    logic       m_dv, m_ovf, m_udf;
    logic       m_pw, m_pr, m_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", tag, n_step, got, exp);
        end
    endtask

    function automatic void model_edge(input logic w, input logic r, input logic c,
                                       input logic [3:0] d, input logic rn);
        logic we, re, ce;
        logic wok, rok;
        int   sz;
        if (!rn) begin
            m_q.delete();
            m_dout = '0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_udf  = 1'b0;
            m_pw = 1'b0; m_pr = 1'b0; m_pc = 1'b0;
            return;
        end
        we = w & ~m_pw;
        re = r & ~m_pr;
        ce = c & ~m_pc;
        m_pw = w; m_pr = r; m_pc = c;
        if (ce) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
            m_dv  = 1'b0;
            return;
        end
        sz  = m_q.size();
        wok = we && (sz < 8 || re);
        rok = re && (sz > 0);
        if (we && sz == 8 && !re) m_ovf = 1'b1;
        if (re && sz == 0)        m_udf = 1'b1;
        m_dv = rok;
        if (rok) m_dout = 4'(m_q.pop_front());
        if (wok) m_q.push_back(int'(d));
    endfunction

    // Drives one cycle of inputs after a falling edge. It lets the rising
    // edge happen, then compares every output on the next falling edge.
    task automatic step(input logic w, input logic r, input logic c,
                        input logic [3:0] d, input logic rn);
        wr_btn = w; rd_btn = r; clr_btn = c; din = d; rst_n = rn;
        @(posedge clk);
        model_edge(w, r, c, d, rn);
        @(negedge clk);
        n_step++;
        $display("[TB] step %0d rn=%0b w=%0b r=%0b c=%0b din=%0h -> dout=%0h dv=%0b cnt=%0d f=%0b e=%0b ovf=%0b udf=%0b",
                 n_step, rn, w, r, c, d, dout, dout_valid, count, full, empty, overflow, underflow);
        check("dout",       dout,       m_dout);
        check("dout_valid", dout_valid, m_dv);
        check("count",      count,      m_q.size());
        check("full",       full,       m_q.size() == 8);
        check("empty",      empty,      m_q.size() == 0);
        check("overflow",   overflow,   m_ovf);
        check("underflow",  underflow,  m_udf);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic push(input logic [3:0] d);
        step(1'b1, 1'b0, 1'b0, d, 1'b1);
        idle();
    endtask

    task automatic pop();
        step(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 1'b1);
        idle();
    endtask

    initial begin
        wr_btn = 1'b0; rd_btn = 1'b0; clr_btn = 1'b0; din = '0; rst_n = 1'b0;
        m_pw = 1'b0; m_pr = 1'b0; m_pc = 1'b0;
        m_dout = '0; m_dv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);

        // Reset values.
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);

        // Fill the FIFO to full, then attempt one write too many.
        for (int i = 1; i <= 8; i++) push(4'(i));
        push(4'hF);
        // Drain it. The words come out as 1..8.
        for (int i = 0; i < 8; i++) pop();

        // A write level held for 20 cycles stores exactly one entry.
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
        idle();
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 4'hA, 1'b1);
        idle();
        pop();

        // Pointer wrap: write 5, read 5, write 6, then read all of them back.
        for (int i = 0; i < 5; i++) push(4'(i));
        for (int i = 0; i < 5; i++) pop();
        for (int i = 0; i < 6; i++) push(4'(i));
        for (int i = 0; i < 6; i++) pop();

        // Empty with a write and a read together: only the write is accepted.
        step(1'b1, 1'b1, 1'b0, 4'h3, 1'b1);
        idle();
        pop();

        // Full with a write and a read together, then clear, then reset.
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
        idle();
        for (int i = 0; i < 8; i++) push(4'(i + 7));
        step(1'b1, 1'b1, 1'b0, 4'hC, 1'b1);
        idle();
        pop();
        push(4'h5);
        step(1'b0, 1'b0, 1'b1, 4'h0, 1'b1);
        idle();
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        // A write level held across reset release fires once afterwards.
        step(1'b1, 1'b0, 1'b0, 4'h9, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 4'h9, 1'b1);
        idle();
        pop();

        // Randomized traffic.
        for (int i = 0; i < 1200; i++) begin
            step($urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 40) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 80) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
